// File: rtl/k_alu_scheduler.sv
// rtl/k_alu_scheduler.sv - two-requester round-robin scheduler for a shared add/sub/mul ALU
module k_alu_scheduler #(
  parameter int EXEC_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] op0,
  input  logic [1:0] op1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic [1:0] ack,
  output logic [7:0] result,
  output logic       result_id,
  output logic       err,
  output logic       busy,
  output logic [3:0] alu_r1,
  output logic [3:0] alu_r2,
  output logic [1:0] alu_switch,
  input  logic [7:0] alu_r3
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic       gnt_q, gnt_d;
  logic       last_q, last_d;
  logic [7:0] result_q, result_d;
  logic       rid_q, rid_d;
  logic       err_q, err_d;
  logic       pick;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= 4'd0;
      op_q     <= 2'd0;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      result_q <= 8'h00;
      rid_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      result_q <= result_d;
      rid_q    <= rid_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req != 2'b00) state_d = EXEC;
      EXEC:    if (cnt_q == 4'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // On a tie the requester not granted last time wins.
  always_comb begin
    pick     = (req == 2'b11) ? ~last_q : req[1];
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    result_d = result_q;
    rid_d    = rid_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          gnt_d = pick;
          op_d  = pick ? op1 : op0;
          a_d   = pick ? a1 : a0;
          b_d   = pick ? b1 : b0;
          cnt_d = CNT_INIT;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          result_d = (op_q == 2'b11) ? 8'h00 : alu_r3;
          rid_d    = gnt_q;
          err_d    = (op_q == 2'b11);
        end
      end
      DONE:    last_d = gnt_q;
      default: ;
    endcase
  end

  always_comb begin
    ack        = 2'b00;
    alu_r1     = 4'd0;
    alu_r2     = 4'd0;
    alu_switch = 2'd0;
    busy       = (state_q != IDLE);
    result     = result_q;
    result_id  = rid_q;
    err        = err_q;
    if (state_q == DONE) ack = gnt_q ? 2'b10 : 2'b01;
    if (state_q == EXEC) begin
      alu_r1     = a_q;
      alu_r2     = b_q;
      alu_switch = op_q;
    end
  end

endmodule

// File: tb/tb_k_alu_scheduler.sv
// tb/tb_k_alu_scheduler.sv - self-checking bench for k_alu_scheduler with a schedule-based reference model
module tb_k_alu_scheduler;

  localparam int EXEC = 2;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic [1:0] op0, op1;
  logic [3:0] a0, b0, a1, b1;
  logic [1:0] ack;
  logic [7:0] result;
  logic       result_id, err, busy;
  logic [3:0] alu_r1, alu_r2;
  logic [1:0] alu_switch;
  logic [7:0] alu_r3;

  int errors = 0;
  int checks = 0;

  k_alu_scheduler #(.EXEC_CYCLES(EXEC)) dut (
    .clk(clk), .reset(reset), .req(req),
    .op0(op0), .op1(op1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack(ack), .result(result), .result_id(result_id), .err(err), .busy(busy),
    .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_switch(alu_switch), .alu_r3(alu_r3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: op 11 returns junk the scheduler must discard.
  always_comb begin
    case (alu_switch)
      2'd0:    alu_r3 = {4'h0, 4'(alu_r1 + alu_r2)};
      2'd1:    alu_r3 = {4'h0, 4'(alu_r1 - alu_r2)};
      2'd2:    alu_r3 = 8'(alu_r1) * 8'(alu_r2);
      default: alu_r3 = 8'hA5;
    endcase
  end

  function automatic logic [7:0] expect_result(logic [1:0] op, logic [3:0] a, logic [3:0] b);
    case (op)
      2'd0:    return 8'((int'(a) + int'(b)) % 16);
      2'd1:    return 8'((int'(a) - int'(b) + 16) % 16);
      2'd2:    return 8'(int'(a) * int'(b));
      default: return 8'h00;
    endcase
  endfunction

  // Model: each operation is a window of edges starting at its request sample edge s.
  int         e_now = 0;
  int         m_s = 0;
  bit         m_valid = 0;
  bit         m_active = 0;
  bit         m_last = 1;
  bit         m_id = 0;
  logic [1:0] m_op = 0;
  logic [3:0] m_a = 0, m_b = 0;
  logic [7:0] m_result = 0;
  bit         m_rid = 0;

  always @(posedge clk) begin
    e_now = e_now + 1;
    if (reset) begin
      m_valid  = 1;
      m_active = 0;
      m_last   = 1;
      m_result = 8'h00;
      m_rid    = 0;
    end else if (!m_active) begin
      if (req != 2'b00) begin
        m_id     = (req == 2'b11) ? !m_last : req[1];
        m_op     = m_id ? op1 : op0;
        m_a      = m_id ? a1 : a0;
        m_b      = m_id ? b1 : b0;
        m_s      = e_now;
        m_active = 1;
      end
    end else if (e_now == m_s + EXEC) begin
      m_result = expect_result(m_op, m_a, m_b);
      m_rid    = m_id;
    end else if (e_now == m_s + EXEC + 1) begin
      m_active = 0;
      m_last   = m_id;
    end
  end

  always @(negedge clk) begin
    logic       x_exec, x_done;
    logic [22:0] got, exp;
    if (m_valid) begin
      x_exec = m_active && (e_now - m_s) < EXEC;
      x_done = m_active && (e_now == m_s + EXEC);
      got = {ack, busy, err, result, result_id, alu_r1, alu_r2, alu_switch};
      exp = {x_done ? (m_id ? 2'b10 : 2'b01) : 2'b00,
             1'(m_active), 1'(x_done && m_op == 2'b11), m_result, 1'(m_rid),
             x_exec ? m_a : 4'd0, x_exec ? m_b : 4'd0, x_exec ? m_op : 2'd0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL model_cycle edge=%0d got ack/busy/err/res/id/r1/r2/sw=%h required %h", e_now, got, exp);
      end
    end
  end

  task automatic chk(string name, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  initial begin
    int         ng;
    logic [1:0] g [4];
    reset = 1'b1; req = 2'b00;
    op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    repeat (3) @(negedge clk);
    chk("reset_ack", 8'(ack), 8'h00);
    chk("reset_busy", 8'(busy), 8'h00);
    chk("reset_result", result, 8'h00);
    chk("reset_id", 8'(result_id), 8'h00);
    chk("reset_err", 8'(err), 8'h00);
    reset = 1'b0;
    @(negedge clk);

    op0 = 2'd0; a0 = 4'd9; b0 = 4'd8; req = 2'b01;
    @(negedge clk); chk("add_busy", 8'(busy), 8'h01);
    @(negedge clk);
    @(negedge clk);
    chk("add_ack", 8'(ack), 8'h01);
    chk("add_result", result, 8'h01);
    chk("add_id", 8'(result_id), 8'h00);
    chk("add_err", 8'(err), 8'h00);
    req = 2'b00;
    @(negedge clk); chk("add_ack_single", 8'(ack), 8'h00);

    op1 = 2'd1; a1 = 4'd3; b1 = 4'd5; req = 2'b10;
    repeat (3) @(negedge clk);
    chk("sub_ack", 8'(ack), 8'h02);
    chk("sub_result", result, 8'h0E);
    chk("sub_id", 8'(result_id), 8'h01);
    req = 2'b00;
    @(negedge clk);

    op0 = 2'd2; a0 = 4'd15; b0 = 4'd15; req = 2'b01;
    @(negedge clk); chk("mul_sw1", 8'(alu_switch), 8'h02);
    @(negedge clk); chk("mul_sw2", 8'(alu_switch), 8'h02);
    @(negedge clk);
    chk("mul_result", result, 8'hE1);
    chk("mul_sw_done", 8'(alu_switch), 8'h00);
    req = 2'b00;
    @(negedge clk);

    op1 = 2'd3; a1 = 4'd7; b1 = 4'd7; req = 2'b10;
    repeat (3) @(negedge clk);
    chk("ill_ack", 8'(ack), 8'h02);
    chk("ill_err", 8'(err), 8'h01);
    chk("ill_result", result, 8'h00);
    req = 2'b00;
    @(negedge clk); chk("ill_err_clear", 8'(err), 8'h00);

    op0 = 2'd0; a0 = 4'd2; b0 = 4'd3; req = 2'b01;
    @(negedge clk);
    op0 = 2'd2; a0 = 4'd9; b0 = 4'd9; req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("hold_ack", 8'(ack), 8'h01);
    chk("hold_result", result, 8'h05);
    @(negedge clk);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    op0 = 2'd0; a0 = 4'd1; b0 = 4'd1; op1 = 2'd2; a1 = 4'd2; b1 = 4'd3; req = 2'b11;
    ng = 0;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        g[ng] = ack;
        ng++;
      end
    end
    req = 2'b00;
    chk("rr_count", 8'(ng), 8'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < ng) chk($sformatf("rr_grant%0d", k), 8'(g[k]), (k % 2 == 1) ? 8'h02 : 8'h01);
    end
    @(negedge clk);

    op0 = 2'd0; a0 = 4'd4; b0 = 4'd4; req = 2'b01;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ack", 8'(ack), 8'h00);
    chk("abort_busy", 8'(busy), 8'h00);
    chk("abort_result", result, 8'h00);
    reset = 1'b0; req = 2'b11;
    repeat (3) @(negedge clk);
    chk("abort_tie_ack", 8'(ack), 8'h01);
    req = 2'b00;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/k_alu_scheduler.md
K_ALU_SCHEDULER -- requirements
Module: k_alu_scheduler

Interface
REQ-001 The module SHALL have parameter EXEC_CYCLES, default 2: cycles spent in EXEC waiting for the shared ALU result to settle; legal range 1..15.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port req, input, 2 bits: per-requester request, index 0 and 1.
REQ-005 The module SHALL have ports op0/op1, input, 2 bits each: requester opcode (00 add, 01 sub, 10 mul, 11 illegal).
REQ-006 The module SHALL have ports a0/b0 and a1/b1, input, 4 bits each: requester operands.
REQ-007 The module SHALL have port ack, input-independent output, 2 bits: one-cycle completion pulse to the granted requester.
REQ-008 The module SHALL have port result, output, 8 bits: last completed result, held until the next completion.
REQ-009 The module SHALL have port result_id, output, 1 bit: requester index that owns result.
REQ-010 The module SHALL have port err, output, 1 bit: high with ack when the completed opcode was 11.
REQ-011 The module SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-012 The module SHALL have ports alu_r1/alu_r2, output, 4 bits each; alu_switch, output, 2 bits; alu_r3, input, 8 bits: connection to the shared add/sub/mul ALU.

Function
REQ-013 The FSM SHALL have states IDLE, EXEC and DONE.
REQ-014 IDLE with req!=0 SHALL grant exactly one requester, latch its op/a/b into internal registers, load the wait counter with EXEC_CYCLES-1 and go to EXEC.
REQ-015 Arbitration SHALL be round-robin: a single active request wins; with both active, the requester not granted last wins.
REQ-016 The last-granted register SHALL update in DONE; after reset it SHALL equal 1, so requester 0 wins the first tie.
REQ-017 In EXEC, alu_r1, alu_r2 and alu_switch SHALL be driven from the latched a, b and op; outside EXEC they SHALL be 0.
REQ-018 EXEC SHALL decrement the counter each cycle; at counter==0 it SHALL capture the result and go to DONE.
REQ-019 The captured result SHALL be alu_r3 for op 00, 01 and 10; add/sub sums are 4 bits zero-extended, carry and borrow discarded, so the ALU returns {4'b0,sum}. For op 11 it SHALL be 8'h00 with err set.
REQ-020 DONE SHALL assert ack[granted] for exactly one cycle, update result, result_id and err, then go to IDLE unconditionally.
REQ-021 Latency SHALL be EXEC_CYCLES+1 cycles from the edge sampling req in IDLE to the ack cycle.
REQ-022 A requester SHALL hold req, op and operands until ack; a req still high in IDLE after DONE SHALL count as a new request.
REQ-023 Operand or opcode changes during EXEC SHALL NOT affect the in-flight operation.
REQ-024 A req deasserted before ack SHALL NOT abort the operation; ack SHALL still pulse.
REQ-025 err SHALL be low in every cycle except a DONE cycle for op 11.

Reset
REQ-026 On reset high at a clock edge, the module SHALL enter IDLE and clear ack, busy, err, result (8'h00), result_id (0) and the counter, and set last-granted to 1.
REQ-027 Reset during EXEC or DONE SHALL abandon the operation with no ack; the abandoned requester SHALL re-request.

Verification
REQ-028 Requester 0: op=00, a=9, b=8, EXEC_CYCLES=2 -> ack=01 three cycles after the req sample; result=8'h01; result_id=0; err=0.
REQ-029 Requester 1: op=01, a=3, b=5 -> ack=10; result=8'h0E; result_id=1.
REQ-030 Requester 0: op=10, a=15, b=15 -> result=8'hE1; alu_switch=10 throughout EXEC.
REQ-031 Both req held high continuously after reset -> grants alternate 0,1,0,1; each ack pulse is one cycle; busy drops for one IDLE cycle between operations.
REQ-032 op=11 -> result=8'h00 and err=1 for the ack cycle only; err low in the next cycle.
REQ-033 Reset asserted in the second EXEC cycle -> no ack, busy=0 and result=8'h00 in the next cycle; a tie afterwards grants requester 0.
